// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage pipeline. Forwarding muxes, ALU,
// destination select and the EX/MEM pipeline register.
// Define EXEC_MUL_EN to build the iterative shift-add multiplier (op 011),
// which stalls upstream for DATA_W+1 cycles; otherwise op 011 yields 0.
module execute_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regWriteE,
  input  logic              memToRegE,
  input  logic              memWriteE,
  input  logic              aluSrcE,
  input  logic              regDstE,
  input  logic [2:0]        aluControlE,
  input  logic [DATA_W-1:0] rd1E,
  input  logic [DATA_W-1:0] rd2E,
  input  logic [DATA_W-1:0] signImmE,
  input  logic [REG_W-1:0]  rtE,
  input  logic [REG_W-1:0]  rdE,
  input  logic [1:0]        forwardAE,
  input  logic [1:0]        forwardBE,
  input  logic [DATA_W-1:0] resultW,
  output logic [REG_W-1:0]  writeRegE,
  output logic              stallE,
  output logic              regWriteM,
  output logic              memToRegM,
  output logic              memWriteM,
  output logic [DATA_W-1:0] aluOutM,
  output logic [DATA_W-1:0] writeDataM,
  output logic [REG_W-1:0]  writeRegM
);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_MUL = 3'b011,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] alu_result;
  logic              stall;
  logic              bubble;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;

  // Operand forwarding; code 11 falls back to the register-file value.
  always_comb begin
    src_a = rd1E;
    fwd_b = rd2E;
    case (forwardAE)
      2'b01:   src_a = resultW;
      2'b10:   src_a = aluOutM;
      default: src_a = rd1E;
    endcase
    case (forwardBE)
      2'b01:   fwd_b = resultW;
      2'b10:   fwd_b = aluOutM;
      default: fwd_b = rd2E;
    endcase
    src_b = aluSrcE ? signImmE : fwd_b;
  end

  assign writeRegE = regDstE ? rdE : rtE;

  // Single-cycle ALU; multiply is handled by the iterative unit below.
  always_comb begin
    alu_result = '0;
    case (alu_op_e'(aluControlE))
      OP_ADD:  alu_result = src_a + src_b;
      OP_SUB:  alu_result = src_a - src_b;
      OP_AND:  alu_result = src_a & src_b;
      OP_OR:   alu_result = src_a | src_b;
      OP_SLT:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_e            state;
  state_e            next_state;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  count;
  logic              is_mul;

  assign is_mul = (aluControlE == OP_MUL);

  // Multiply FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next state, stall and bubble insertion.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    bubble     = 1'b0;
    case (state)
      IDLE: begin
        if (is_mul) begin
          stall      = 1'b1;
          bubble     = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        stall  = 1'b1;
        bubble = 1'b1;
        if (count == LAST) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Shift-add datapath; operands are captured at issue so forwarding
  // changes during BUSY cannot corrupt the product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mul) begin
            mcand  <= src_a;
            mplier <= src_b;
            acc    <= '0;
            count  <= '0;
          end
        end
        BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign mul_done    = (state == DONE);
  assign mul_product = acc;
`else
  assign stall       = 1'b0;
  assign bubble      = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  assign stallE = stall;

  // EX/MEM pipeline register; bubbles while a multiply occupies EX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regWriteM  <= 1'b0;
      memToRegM  <= 1'b0;
      memWriteM  <= 1'b0;
      aluOutM    <= '0;
      writeDataM <= '0;
      writeRegM  <= '0;
    end else if (bubble) begin
      regWriteM  <= 1'b0;
      memToRegM  <= 1'b0;
      memWriteM  <= 1'b0;
      aluOutM    <= '0;
      writeDataM <= '0;
      writeRegM  <= '0;
    end else begin
      regWriteM  <= regWriteE;
      memToRegM  <= memToRegE;
      memWriteM  <= memWriteE;
      aluOutM    <= mul_done ? mul_product : alu_result;
      writeDataM <= fwd_b;
      writeRegM  <= writeRegE;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed bench for execute_stage with a timeline-based
// reference model checked every negedge, plus literal spot checks.
module tb_execute_stage;

  localparam int DW = 32;
  localparam int RW = 5;

`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          regWriteE, memToRegE, memWriteE, aluSrcE, regDstE;
  logic [2:0]    aluControlE;
  logic [DW-1:0] rd1E, rd2E, signImmE, resultW;
  logic [RW-1:0] rtE, rdE;
  logic [1:0]    forwardAE, forwardBE;
  logic [RW-1:0] writeRegE;
  logic          stallE, regWriteM, memToRegM, memWriteM;
  logic [DW-1:0] aluOutM, writeDataM;
  logic [RW-1:0] writeRegM;

  int total = 0;
  int bad   = 0;

  execute_stage #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk(clk), .rst(rst),
    .regWriteE(regWriteE), .memToRegE(memToRegE), .memWriteE(memWriteE),
    .aluSrcE(aluSrcE), .regDstE(regDstE), .aluControlE(aluControlE),
    .rd1E(rd1E), .rd2E(rd2E), .signImmE(signImmE),
    .rtE(rtE), .rdE(rdE), .forwardAE(forwardAE), .forwardBE(forwardBE),
    .resultW(resultW), .writeRegE(writeRegE), .stallE(stallE),
    .regWriteM(regWriteM), .memToRegM(memToRegM), .memWriteM(memWriteM),
    .aluOutM(aluOutM), .writeDataM(writeDataM), .writeRegM(writeRegM)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mul_edges: 0 = no multiply in EX, k = k edges since the mul issued.
  int unsigned   mul_edges;
  logic [DW-1:0] m_prod, ma, mfb, mb;
  logic          m_rw, m_mr, m_mw;
  logic [DW-1:0] m_alu, m_wd;
  logic [RW-1:0] m_wr;

  function automatic logic [DW-1:0] pick(input logic [1:0] sel, input logic [DW-1:0] rv);
    if (sel == 2'b01) return resultW;
    if (sel == 2'b10) return m_alu;
    return rv;
  endfunction

  function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return ($signed(a) < $signed(b)) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // Model of the EX/MEM register contents after each edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rw = 0; m_mr = 0; m_mw = 0; m_alu = 0; m_wd = 0; m_wr = 0;
      mul_edges = 0;
    end else begin
      ma  = pick(forwardAE, rd1E);
      mfb = pick(forwardBE, rd2E);
      mb  = aluSrcE ? signImmE : mfb;
      if (MUL_EN && mul_edges == 0 && aluControlE == 3'b011) begin
        m_prod = ma * mb;
        mul_edges = 1;
        m_rw = 0; m_mr = 0; m_mw = 0; m_alu = 0; m_wd = 0; m_wr = 0;
      end else if (mul_edges >= 1 && mul_edges <= DW) begin
        mul_edges++;
        m_rw = 0; m_mr = 0; m_mw = 0; m_alu = 0; m_wd = 0; m_wr = 0;
      end else begin
        m_alu = (mul_edges == DW + 1) ? m_prod : ref_alu(aluControlE, ma, mb);
        m_rw = regWriteE; m_mr = memToRegE; m_mw = memWriteE;
        m_wd = mfb;
        m_wr = regDstE ? rdE : rtE;
        mul_edges = 0;
      end
    end
  end

  // Compare DUT to model every cycle, away from the active edge.
  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = MUL_EN && ((mul_edges == 0 && aluControlE == 3'b011) ||
                           (mul_edges >= 1 && mul_edges <= DW));
    check("cmp_regWriteM", regWriteM, m_rw);
    check("cmp_memToRegM", memToRegM, m_mr);
    check("cmp_memWriteM", memWriteM, m_mw);
    check("cmp_aluOutM", aluOutM, m_alu);
    check("cmp_writeDataM", writeDataM, m_wd);
    check("cmp_writeRegM", writeRegM, m_wr);
    check("cmp_writeRegE", writeRegE, regDstE ? rdE : rtE);
    check("cmp_stallE", stallE, exp_stall);
  end

  // ---------------- directed stimulus ----------------
  typedef struct packed {
    logic [2:0]    op;
    logic          src;
    logic          dst;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    aluControlE = op; rd1E = a; rd2E = b;
    forwardAE = 2'b00; forwardBE = 2'b00; aluSrcE = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs = '{
      '{3'b110, 1'b0, 1'b1, 32'd3,        32'd5,      32'd0,        32'hFFFF_FFFE},
      '{3'b000, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0FF0,  32'd0,        32'h0000_00F0},
      '{3'b001, 1'b0, 1'b1, 32'h0000_F000, 32'h000F,  32'd0,        32'h0000_F00F},
      '{3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2,     32'd0,        32'd1},
      '{3'b100, 1'b0, 1'b1, 32'd9,        32'd9,      32'd0,        32'd0},
      '{3'b101, 1'b0, 1'b0, 32'd9,        32'd9,      32'd0,        32'd0},
      '{3'b010, 1'b1, 1'b1, 32'd10,       32'd77,     32'hFFFF_FFFC, 32'd6}
    };

    rst = 1'b0;
    regWriteE = 1'b1; memToRegE = 1'b0; memWriteE = 1'b0;
    aluSrcE = 1'b0; regDstE = 1'b1; aluControlE = 3'b010;
    rd1E = 0; rd2E = 0; signImmE = 0; resultW = 0;
    rtE = 5'd3; rdE = 5'd7; forwardAE = 2'b00; forwardBE = 2'b00;

    // Reset state before any clock edge.
    #2;
    check("reset_aluOutM", aluOutM, 0);
    check("reset_regWriteM", regWriteM, 0);
    check("reset_stallE", stallE, 0);
    step();
    #5 rst = 1'b1;

    // ALU table: result, store data and destination register.
    for (int i = 0; i < 7; i++) begin
      set_op(vecs[i].op, vecs[i].a, vecs[i].b);
      aluSrcE = vecs[i].src; regDstE = vecs[i].dst; signImmE = vecs[i].imm;
      memToRegE = i[0];
      step();
      check("table_aluOutM", aluOutM, vecs[i].exp);
      check("table_writeDataM", writeDataM, vecs[i].b);
      check("table_writeRegM", writeRegM, vecs[i].dst ? 5'd7 : 5'd3);
    end

    // Asynchronous reset mid-stream, between edges.
    #2 rst = 1'b0;
    #1;
    check("async_rst_aluOutM", aluOutM, 0);
    check("async_rst_writeDataM", writeDataM, 0);
    check("async_rst_writeRegM", writeRegM, 0);
    check("async_rst_regWriteM", regWriteM, 0);
    #2 rst = 1'b1;

    // Forward from M.
    regDstE = 1'b1; memToRegE = 1'b0;
    set_op(3'b010, 32'd2, 32'd3);
    step();
    check("fwd_setup_aluOutM", aluOutM, 5);
    set_op(3'b010, 32'd100, 32'd3);
    forwardAE = 2'b10;
    step();
    check("fwdM_aluOutM", aluOutM, 8);
    check("fwdM_writeRegM", writeRegM, 7);

    // Forward from W into signed slt.
    set_op(3'b111, 32'hFFFF_FFFF, 32'd99);
    forwardBE = 2'b01; resultW = 32'd1;
    step();
    check("slt_neg_aluOutM", aluOutM, 1);
    rd1E = 32'd2;
    step();
    check("slt_pos_aluOutM", aluOutM, 0);

    // Multiply 7 x 6 with stall.
    set_op(3'b011, 32'd7, 32'd6);
    regWriteE = 1'b1;
    #1;
    check("mul_issue_stallE", stallE, MUL_EN);
    for (int i = 1; i <= DW; i++) begin
      step();
      check("mul_busy_stallE", stallE, MUL_EN);
      check("mul_busy_regWriteM", regWriteM, !MUL_EN);
    end
    step();
    check("mul_done_stallE", stallE, 0);
    check("mul_done_regWriteM", regWriteM, !MUL_EN);
    step();
    check("mul_result_aluOutM", aluOutM, MUL_EN ? 42 : 0);
    check("mul_result_regWriteM", regWriteM, 1);

    // Back-to-back: truncating multiply, forwardAE changed during BUSY.
    rd1E = 32'h0001_0000; rd2E = 32'h0001_0000;
    #1;
    check("b2b_issue_stallE", stallE, MUL_EN);
    for (int i = 1; i <= DW + 2; i++) begin
      step();
      if (i == 3) begin
        forwardAE = 2'b01; resultW = 32'd3;
      end
    end
    check("trunc_aluOutM", aluOutM, 0);
    check("trunc_regWriteM", regWriteM, 1);

    // Abort at BUSY count 10, then restart 3 x 4.
    set_op(3'b011, 32'd9, 32'd9);
    for (int i = 0; i < 11; i++) step();
    #2 rst = 1'b0; aluControlE = 3'b010;
    #1;
    check("abort_aluOutM", aluOutM, 0);
    check("abort_regWriteM", regWriteM, 0);
    check("abort_writeRegM", writeRegM, 0);
    check("abort_stallE", stallE, 0);
    #2 rst = 1'b1;
    set_op(3'b011, 32'd3, 32'd4);
    for (int i = 0; i < DW + 2; i++) step();
    check("restart_aluOutM", aluOutM, MUL_EN ? 12 : 0);
    check("restart_regWriteM", regWriteM, 1);

    set_op(3'b010, 32'd0, 32'd0);
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX-stage datapath of the 5-stage pipeline.
- Consumes the ID/EX register outputs and the hazard unit's forwarding selects.
- Computes the ALU result, including an optional iterative 32-cycle multiply, and drives the EX/MEM pipeline register.
- Asserts stallE while a multiply is in flight, so the hazard unit freezes IF/ID/EX.

Parameters:
DATA_W, 32, datapath width; multiply iteration count equals DATA_W
REG_W, 5, register-address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
regWriteE  in  1  register-write control from ID/EX
memToRegE  in  1  load-select control from ID/EX
memWriteE  in  1  store control from ID/EX
aluSrcE  in  1  1 = srcB is signImmE
regDstE  in  1  1 = destination is rdE, else rtE
aluControlE  in  3  ALU operation
rd1E  in  DATA_W  register-file read 1
rd2E  in  DATA_W  register-file read 2
signImmE  in  DATA_W  sign-extended immediate
rtE  in  REG_W  rt field
rdE  in  REG_W  rd field
forwardAE  in  2  00 rd1E, 01 resultW, 10 aluOutM
forwardBE  in  2  same encoding, applied to rd2E
resultW  in  DATA_W  WB-stage result
writeRegE  out  REG_W  combinational destination register, to hazard unit
stallE  out  1  multiply busy, hold upstream stages
regWriteM  out  1  registered control
memToRegM  out  1  registered control
memWriteM  out  1  registered control
aluOutM  out  DATA_W  registered ALU result; also the forwarding source
writeDataM  out  DATA_W  registered forwarded srcB, taken before the immediate mux
writeRegM  out  REG_W  registered destination register

Behaviour:
- Reset (rst low, asynchronous): all M outputs are 0, FSM is IDLE, the multiply counter and accumulator are 0.
- Forwarding:
  - srcA = mux(forwardAE); code 11 selects rd1E.
  - fwdB = mux(forwardBE) over rd2E; code 11 selects rd2E.
  - srcB = aluSrcE ? signImmE : fwdB.
- Destination: writeRegE = regDstE ? rdE : rtE.
- ALU operations:
  - 010 add, 110 sub; both wrap modulo 2^DATA_W, no overflow trap.
  - 000 and, 001 or.
  - 111 slt: signed compare, result 1 or 0 zero-extended.
  - 011 mul: low DATA_W bits of the unsigned product.
  - 100, 101: result 0.
- Non-mul latency: 1 cycle. The M register loads all control, result, fwdB and writeRegE on the next rising edge.
- FSM IDLE:
  - If aluControlE == 011: stallE = 1 combinationally.
  - At the edge: latch srcA into the multiplicand and srcB into the multiplier, clear the accumulator and counter, go to BUSY.
  - The M register loads a bubble on that edge: regWriteM = 0, memWriteM = 0, memToRegM = 0; data fields don't-care, driven 0.
- FSM BUSY:
  - stallE = 1 throughout.
  - Each edge: if multiplier[0] is set, add the multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right, and increment the counter.
  - After DATA_W edges, go to DONE. The M register loads bubbles each edge.
- FSM DONE:
  - stallE = 0.
  - At the edge: the M register loads the accumulator and the E-stage control; state goes to IDLE.
  - The same mul is not reissued, because upstream advances on this edge.
- Total multiply occupancy of EX: DATA_W + 2 cycles. The result is visible on aluOutM DATA_W + 2 edges after the mul first appears in E.
- Upstream is not guaranteed to hold forwarded values during BUSY: operands are latched at issue, so later forwardAE/BE changes have no effect.
- Back-to-back muls: DONE goes to IDLE; the next mul issues on the following cycle.
- Reset asserted during BUSY aborts the multiply with no partial result. The M outputs clear immediately.

Optional Feature:
- Macro: EXEC_MUL_EN.
- Defined: multiply unit and FSM present, as described above.
- Undefined: code 011 yields 0 like the other unsupported codes, stallE is tied 0, and no FSM or accumulator registers are generated.

Test Plan:
- Reset: hold rst low mid-stream → all M outputs are 0 asynchronously, before any clock edge.
- Forward from M: forwardAE = 10, aluOutM = 5, rd2E = 3, aluControlE = 010, aluSrcE = 0 → next edge aluOutM = 8, writeRegM = writeRegE.
- Forward from W, signed slt: forwardBE = 01, resultW = 1, rd1E = 0xFFFFFFFF, aluControlE = 111 → aluOutM = 1. Then rd1E = 2 → aluOutM = 0.
- Multiply with stall: srcA = 7, srcB = 6, aluControlE = 011, regWriteE = 1 → stallE high for 33 cycles, regWriteM = 0 during the stall, then aluOutM = 42 and regWriteM = 1 on edge 34. With EXEC_MUL_EN undefined: stallE never rises and aluOutM = 0.
- Multiply truncation: 0x00010000 × 0x00010000 → aluOutM = 0. Changing forwardAE during BUSY does not alter the result.
- Abort and restart: assert rst at BUSY count 10 → state IDLE, outputs 0. Then reissue 3 × 4 → aluOutM = 12 after 34 cycles.
